// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t state, state_d;
  logic [1:0] op_r;
  logic [WIDTH-1:0] a, b, ma, mb, q_fix, r_fix;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] sum, trial, diff;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, sa, sb;
  always_comb begin
    state_d = (state == IDLE && start) ? PREP :
              (state == PREP) ? CALC :
              (state == CALC && cnt == CW'(WIDTH-1)) ? FIX :
              (state == FIX) ? IDLE : state;
    sa    = !op_r[0] && a[WIDTH-1];
    sb    = !op_r[0] && b[WIDTH-1];
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
    diff  = trial - {1'b0, mb};
    prod  = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_r  <= '0;
      a     <= '0;
      b     <= '0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_d;
      done  <= state == FIX;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a    <= rs_data;
            b    <= rt_data;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        PREP: begin
          ma    <= sa ? -a : a;
          mb    <= sb ? -b : b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_r[1]) begin
            // restoring step: the dividend's MSB is shifted into the partial remainder
            acc <= diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            ma  <= ma << 1;
          end else begin
            acc <= {sum, acc[WIDTH-1:1]};
            mb  <= mb >> 1;
          end
        end
        FIX: begin
          if (!op_r[1]) {hi, lo} <= prod;
          else if (b == '0) begin
            lo <= '1;
            hi <= a;
          end else begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven vectors plus directed corner-case sequences
module tb_mult_div_unit;
  logic clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0, wdata = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, ehi, elo;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] r1, input logic [31:0] r2,
                     output int lat, output int bc, output logic d0, output logic b0);
    @(negedge clk);
    start = 1; op = o; rs_data = r1; rt_data = r2;
    @(posedge clk); #1;
    start = 0; rs_data = 32'h5a5a_0f0f; rt_data = 32'h0;
    d0 = done; b0 = busy;
    lat = 0; bc = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
  endtask
  initial begin
    int lat, bc, ndone;
    logic d0, b0;
    v[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    v[4]  = '{2'b11, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF};
    v[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    v[6]  = '{2'b00, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    v[7]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    v[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    v[9]  = '{2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    v[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    v[11] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      run(v[i].op, v[i].rs, v[i].rt, lat, bc, d0, b0);
      chk($sformatf("v%0d_latency", i), lat, 34);
      chk($sformatf("v%0d_busy_cycles", i), bc, 34);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      chk($sformatf("v%0d_first_cycle", i), {d0, b0}, 2'b01);
      chk($sformatf("v%0d_hi", i), hi, v[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, v[i].elo);
    end
    @(negedge clk);
    hi_we = 1; wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 0;
    chk("mthi_idle", hi, 32'h1111_2222);
    start = 1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; hi_we = 1; wdata = 32'hFFFF;
    @(posedge clk); #1;
    start = 0; hi_we = 0;
    chk("start_beats_mthi", hi, 32'h1111_2222);
    ndone = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
    end
    chk("divu_after_mthi_hi", hi, 32'd2);
    @(negedge clk);
    start = 1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk); #1;
    start = 0; ndone = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin
        @(negedge clk);
        start = 1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3; hi_we = 1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 0; hi_we = 0;
        chk("mthi_while_busy", hi, 32'd2);
      end else begin
        @(posedge clk); #1;
      end
      if (done) ndone++;
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_hi", hi, 0);
    chk("ignored_start_lo", lo, 12);
    chk("ignored_start_idle", busy, 0);
    @(negedge clk);
    start = 1; op = 2'b00; rs_data = 32'hFFFF_FFFD; rt_data = 32'd5;
    @(posedge clk); #1;
    start = 0;
    repeat (15) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 2) rst_n = 1;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_still_idle", busy, 0);
    @(negedge clk);
    lo_we = 1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    lo_we = 0;
    chk("mtlo_after_reset", lo, 32'hA5A5_A5A5);
    chk("mtlo_hi_untouched", hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
